serial_sub16: RTL and testbench
===============================

Name: serial_sub16

Overview:
- Bit-serial two's-complement subtractor: computes d = a - b one bit per clock, LSB first, with a single shared full-subtractor cell and a borrow flip-flop.
- The inverse-direction companion of the team's parallel ripple adder, for area-constrained datapaths where latency is acceptable.
- Produces the difference plus borrow, signed-overflow and zero flags.
- Uses a start/busy/done handshake to the surrounding controller.

Parameters:
- WIDTH, 16, operand and result width in bits (min 2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; result valid.
- d  output  WIDTH  difference a - b mod 2^WIDTH.
- borrow  output  1  final borrow out (1 iff unsigned a < b).
- ovfl  output  1  signed overflow of a - b.
- zero  output  1  d == 0.

Behaviour:
- Reset:
  - Synchronous, active-high; has priority over all other inputs.
  - On the reset edge: FSM goes to IDLE, and busy, done, d, borrow, ovfl, zero all become 0.
  - Internal shift registers, bit counter and borrow FF are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1 at edge 0: latch a and b into shift regs, clear borrow FF, set counter to 0, go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - Each cycle processes bit i = counter, using ai/bi = LSBs of the shift regs and br = borrow FF.
  - diff_i = ai ^ bi ^ br.
  - br_next = (~ai & bi) | (~(ai ^ bi) & br).
  - diff_i is shifted into the MSB of an internal result shift reg; operand regs shift right.
  - After bit WIDTH-1 is processed, go to DONE.
- DONE:
  - Lasts exactly one cycle, then returns to IDLE.
  - start asserted during DONE is ignored.
- Timing, with start accepted at edge 0:
  - busy=1 during cycles 1..WIDTH (WIDTH cycles).
  - done=1 during cycle WIDTH+1 only.
  - With start held high, the next start is accepted in the IDLE cycle after done, so issue interval is WIDTH+2 cycles.
- Result registers:
  - d, borrow, ovfl and zero update only on the edge entering DONE.
  - They hold the previous result throughout RUN and hold the new result until the next completion or reset.
  - borrow = final borrow FF value after bit WIDTH-1.
  - ovfl = (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]), using the captured operands.
  - zero = (d == 0).
- Handshake and inputs:
  - start while busy or done is ignored: no restart, no effect on the operation in progress.
  - a and b are don't-care except on the accepting edge; changes during RUN must not affect the result.
- Reset mid-operation:
  - Aborts immediately; no done pulse is produced for the aborted operation.
  - All outputs read 0 the cycle after the reset edge.
  - start on the first cycle after reset deasserts is accepted normally.
- Boundary cases:
  - a == b gives d=0, zero=1, borrow=0, ovfl=0.
  - b == 0 gives d=a, borrow=0, ovfl=0.

Test Plan:
- a=0x0005, b=0x0003, start at edge 0: busy in cycles 1..16, done in cycle 17; d=0x0002, borrow=0, ovfl=0, zero=0.
- a=0x0003, b=0x0005: d=0xFFFE, borrow=1, ovfl=0, zero=0.
- a=0x8000, b=0x0001: d=0x7FFF, borrow=0, ovfl=1. Also a=0x7FFF, b=0xFFFF: d=0x8000, borrow=1, ovfl=1.
- a=b=0x1234: d=0x0000, zero=1, borrow=0, ovfl=0. Then a=0x1234, b=0x0000: d=0x1234, zero=0, borrow=0, ovfl=0.
- Start accepted with a=9, b=4; pulse start again at cycle 5 with a=1, b=1, and change a/b mid-run: single done at cycle 17 with d=0x0005. Hold start high continuously: done pulses every 18 cycles.
- Start accepted, reset asserted at cycle 8: busy=0, d/flags=0 from cycle 9, no done within 40 cycles. New start with a=2, b=1 gives d=0x0001 at cycle 17 after acceptance.

Source files
------------

// File: rtl/serial_sub16.sv
// Bit-serial two's-complement subtractor: d = a - b, one bit per clock, LSB first.
// Uses a single full-subtractor cell and a borrow flop, with a start/busy/done handshake.
module serial_sub16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             borrow,
  output logic             ovfl,
  output logic             zero
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             br_q;
  logic [CNT_W-1:0] cnt_q;
  logic             a_msb_q;
  logic             b_msb_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] d_q;
  logic             borrow_q;
  logic             ovfl_q;
  logic             zero_q;

  logic             diff_d;
  logic             br_d;
  logic [WIDTH-1:0] res_d;
  logic             ovfl_d;

  // Shared full-subtractor cell and the result word as it will look after this bit.
  always_comb begin
    diff_d = a_q[0] ^ b_q[0] ^ br_q;
    br_d   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    res_d  = {diff_d, res_q[WIDTH-1:1]};
    // Overflow only when operand signs differ and the result sign departs from a's.
    ovfl_d = (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
  end

  // Control FSM, datapath shift registers and registered result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      ovfl_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_q   <= {1'b0, a_q[WIDTH-1:1]};
          b_q   <= {1'b0, b_q[WIDTH-1:1]};
          res_q <= res_d;
          br_q  <= br_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            d_q      <= res_d;
            borrow_q <= br_d;
            ovfl_q   <= ovfl_d;
            zero_q   <= (res_d == '0);
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end else begin
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= ST_RUN;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign d      = d_q;
  assign borrow = borrow_q;
  assign ovfl   = ovfl_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_serial_sub16.sv
// Self-checking bench for serial_sub16: directed vector table, random ops against
// an arithmetic reference model, and hand-written handshake/reset sequences.
module tb_serial_sub16;

  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         borrow;
  logic         ovfl;
  logic         zero;

  int tests;
  int fails;
  logic [W-1:0] prev_d;

  serial_sub16 #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .d(d), .borrow(borrow), .ovfl(ovfl), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] ed;
    logic         eb;
    logic         eo;
    logic         ez;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       output logic [W-1:0] md, output logic mbr,
                       output logic mo, output logic mz);
    int sa;
    int sb;
    int sd;
    sa  = int'($signed(ma));
    sb  = int'($signed(mb));
    sd  = sa - sb;
    md  = W'(int'(ma) - int'(mb));
    mbr = (int'(ma) < int'(mb));
    mo  = (sd > 32767) || (sd < -32768);
    mz  = (md == '0);
  endtask

  // One full operation from IDLE; checks handshake timing and the result.
  task automatic run_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] ed, input logic eb, input logic eo, input logic ez);
    logic timing_ok;
    start = 1'b1;
    a = va;
    b = vb;
    tick();
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    check({tag, "_hold_d"}, 32'(d), 32'(prev_d));
    timing_ok = 1'b1;
    for (int c = 1; c <= W; c++) begin
      if (busy !== 1'b1 || done !== 1'b0) timing_ok = 1'b0;
      a = $urandom;
      b = $urandom;
      tick();
    end
    check({tag, "_busy_window"}, 32'(timing_ok), 32'd1);
    check({tag, "_done_flags"}, {30'd0, done, busy}, {30'd0, 1'b1, 1'b0});
    check({tag, "_d"}, 32'(d), 32'(ed));
    check({tag, "_bor_ovf_zero"}, {29'd0, borrow, ovfl, zero}, {29'd0, eb, eo, ez});
    tick();
    check({tag, "_done_pulse_end"}, 32'(done), 32'd0);
    prev_d = ed;
  endtask

  initial begin
    logic [W-1:0] ra, rb, md;
    logic mbr, mo, mz;
    int dcnt, dcyc, dlist[$];
    logic [W-1:0] dval;
    logic done_seen;

    tests = 0;
    fails = 0;
    prev_d = '0;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;

    vecs[0] = '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0};

    tick();
    tick();
    check("reset_outputs", {26'd0, busy, done, borrow, ovfl, zero, 1'b0} | 32'(d), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].ed,
             vecs[i].eb, vecs[i].eo, vecs[i].ez);
    end

    for (int i = 0; i < 25; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 0) rb = ra;
      if (i == 1) rb = '0;
      model(ra, rb, md, mbr, mo, mz);
      run_op($sformatf("rand%0d", i), ra, rb, md, mbr, mo, mz);
    end

    // start pulsed mid-run with fresh operands must be ignored
    start = 1'b1;
    a = 16'd9;
    b = 16'd4;
    tick();
    dcnt = 0;
    dcyc = 0;
    dval = '0;
    for (int c = 1; c <= 30; c++) begin
      if (done === 1'b1) begin
        dcnt++;
        dcyc = c;
        dval = d;
      end
      start = (c == 5);
      a = (c == 5) ? 16'd1 : W'($urandom);
      b = (c == 5) ? 16'd1 : W'($urandom);
      tick();
    end
    start = 1'b0;
    check("midrun_done_count", 32'(dcnt), 32'd1);
    check("midrun_done_cycle", 32'(dcyc), 32'd17);
    check("midrun_d", 32'(dval), 32'h5);
    prev_d = 16'h5;

    // start held high: back-to-back operations every WIDTH+2 cycles
    start = 1'b1;
    a = 16'h00F0;
    b = 16'h000F;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (done === 1'b1) begin
        dlist.push_back(c);
        check($sformatf("held_d_c%0d", c), 32'(d), 32'h00E1);
      end
    end
    start = 1'b0;
    check("held_done_count", 32'(dlist.size()), 32'd3);
    if (dlist.size() >= 1) check("held_first_done", 32'(dlist[0]), 32'd17);
    for (int k = 1; k < dlist.size(); k++)
      check($sformatf("held_interval%0d", k), 32'(dlist[k] - dlist[k-1]), 32'd18);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    prev_d = '0;

    // reset in the middle of an operation aborts it
    start = 1'b1;
    a = 16'h4321;
    b = 16'h0123;
    tick();
    start = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    check("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    check("abort_outputs_zero", {26'd0, busy, done, borrow, ovfl, zero, 1'b0} | 32'(d), 32'd0);
    reset = 1'b0;
    done_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
      tick();
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    run_op("after_abort", 16'd2, 16'd1, 16'h0001, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the bench cannot hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
